custom_subtractor47_21: RTL and testbench

CUSTOM_SUBTRACTOR47_21 -- requirements
Module: custom_subtractor47_21

---
 rtl/custom_subtractor47_21.sv | 133 +++++++++++++
 tb/tb_custom_subtractor47_21.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/custom_subtractor47_21.sv
// Multi-cycle subtractor: Diff = {borrow, (A - B) mod 2^47}, computed
// CHUNK_W bits per cycle, least significant slice first, behind a
// valid/ready handshake on both sides.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready high once out of reset
// RUN   | subtracting one slice per edge, in_valid ignored
// DONE  | result held on Diff with out_valid high until out_ready
module custom_subtractor47_21 #(
    parameter int CHUNK_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [46:0] A,
    input  logic [20:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] Diff
);

    localparam int NUM_CHUNKS = (47 + CHUNK_W - 1) / CHUNK_W;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [46:0]       a_work_q;
    logic [46:0]       b_work_q;
    logic [46:0]       acc_q;
    logic              borrow_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [47:0]       diff_q;

    logic              accept;
    logic              last_slice;
    logic [CHUNK_W:0]  slice_res;
    logic [5:0]        slice_lo;
    logic [46:0]       slice_mask;
    logic [46:0]       slice_pos;
    logic [46:0]       acc_next;

    // in_ready is registered, so nothing is taken on the first edge after reset
    assign accept     = (state_q == IDLE) && in_valid && in_ready_q;
    assign last_slice = (state_q == RUN) && (cnt_q == LAST_CNT);

    // One slice of the subtraction. The operands are shifted down each edge,
    // so the live slice is always the low CHUNK_W bits; above bit 46 the
    // working registers hold zeros, which makes the top bit of slice_res the
    // borrow out of bit 46 even when the final slice is narrower than CHUNK_W.
    always_comb begin
        slice_res  = {1'b0, a_work_q[CHUNK_W-1:0]}
                   - {1'b0, b_work_q[CHUNK_W-1:0]}
                   - {{CHUNK_W{1'b0}}, borrow_q};
        slice_lo   = 6'(int'(cnt_q) * CHUNK_W);
        slice_mask = 47'({CHUNK_W{1'b1}}) << slice_lo;
        slice_pos  = 47'(slice_res[CHUNK_W-1:0]) << slice_lo;
        acc_next   = (acc_q & ~slice_mask) | (slice_pos & slice_mask);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    // Working registers, slice counter, borrow chain and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_work_q <= '0;
            b_work_q <= '0;
            acc_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
        end else if (accept) begin
            a_work_q <= A;
            b_work_q <= {26'b0, B};
            acc_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            a_work_q <= a_work_q >> CHUNK_W;
            b_work_q <= b_work_q >> CHUNK_W;
            acc_q    <= acc_next;
            borrow_q <= slice_res[CHUNK_W];
            cnt_q    <= cnt_q + 1'b1;
            if (last_slice) begin
                diff_q <= {slice_res[CHUNK_W], acc_next};
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Diff      = diff_q;

endmodule

// File: tb/tb_custom_subtractor47_21.sv
// Directed bench for custom_subtractor47_21 at CHUNK_W = 8, with a
// scoreboard queue of expected differences.
module tb_custom_subtractor47_21;

    localparam int CW = 8;
    localparam int NC = (47 + CW - 1) / CW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [46:0] a = '0;
    logic [20:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [47:0] diff;

    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    logic [47:0] sb[$];

    custom_subtractor47_21 #(.CHUNK_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (diff)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [47:0] model(input logic [46:0] av, input logic [20:0] bv);
        return {1'b0, av} - {27'b0, bv};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [46:0] av, input logic [20:0] bv, output int acc_cyc);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        check("send_in_ready", 48'(in_ready), 48'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        sb.push_back(model(av, bv));
        check("run_in_ready", 48'(in_ready), 48'd0);
    endtask

    task automatic collect(input string tag, input int acc_cyc, output logic [47:0] exp);
        int n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            tick;
            n++;
        end
        check("latency", 48'(cyc - acc_cyc), 48'(NC));
        if (sb.size() > 0) exp = sb.pop_front();
        else exp = 48'hBAD0_BAD0_BAD0;
        check(tag, diff, exp);
        check("done_in_ready", 48'(in_ready), 48'd0);
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        tick;
        check("hs_out_valid", 48'(out_valid), 48'd0);
        check("hs_in_ready", 48'(in_ready), 48'd1);
    endtask

    task automatic full_op(input string tag, input logic [46:0] av, input logic [20:0] bv);
        int          acc;
        logic [47:0] e;
        send(av, bv, acc);
        collect(tag, acc, e);
        handshake;
    endtask

    initial begin
        int          acc1;
        int          acc2;
        logic [47:0] e;

        // reset behaviour
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", 48'(in_ready), 48'd0);
        check("rst_out_valid", 48'(out_valid), 48'd0);
        check("rst_diff", diff, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check("post_rst_in_ready", 48'(in_ready), 48'd1);

        // directed values
        full_op("a100_b1", 47'd100, 21'd1);
        check("a100_b1_const", diff, 48'h0000_0000_0063);
        full_op("a0_b1", 47'd0, 21'd1);
        check("a0_b1_const", diff, 48'hFFFF_FFFF_FFFF);
        full_op("amax_bmax", 47'h7FFF_FFFF_FFFF, 21'h1F_FFFF);
        check("amax_bmax_const", diff, 48'h7FFF_FFE0_0000);
        full_op("borrow_chain", 47'h0_0000_0100, 21'd1);
        check("borrow_chain_const", diff, 48'h0000_0000_00FF);
        full_op("long_chain", 47'h0100_0000_0000, 21'd1);
        full_op("a_eq_b", 47'd12345, 21'd12345);
        check("a_eq_b_const", diff, 48'h0);
        full_op("b_zero", 47'h5A5A_1234_5678, 21'd0);
        check("b_zero_const", diff, {1'b0, 47'h5A5A_1234_5678});

        // streaming throughput: next accept C+2 edges after the previous one
        send(47'd1000, 21'd999, acc1);
        collect("stream0", acc1, e);
        handshake;
        send(47'd7, 21'd9, acc2);
        check("throughput", 48'(acc2 - acc1), 48'(NC + 2));
        collect("stream1", acc2, e);
        handshake;

        // backpressure with ignored in_valid pulses
        out_ready = 1'b0;
        send(47'h1234_5678_9ABC, 21'h1_2345, acc1);
        collect("bp_result", acc1, e);
        for (int i = 0; i < 3; i++) begin
            a        = 47'($urandom);
            b        = 21'($urandom);
            in_valid = 1'b1;
            tick;
            check("bp_out_valid", 48'(out_valid), 48'd1);
            check("bp_diff_stable", diff, e);
            check("bp_in_ready", 48'(in_ready), 48'd0);
        end
        in_valid = 1'b0;
        handshake;

        // reset in the middle of RUN
        send(47'h7777_0000_0000, 21'd3, acc1);
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 48'(out_valid), 48'd0);
        check("mid_rst_diff", diff, 48'd0);
        check("mid_rst_in_ready", 48'(in_ready), 48'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check("mid_rst_ready_back", 48'(in_ready), 48'd1);
        full_op("after_rst", 47'd5, 21'd3);
        check("after_rst_const", diff, 48'd2);

        // a few random operand pairs
        for (int i = 0; i < 6; i++) begin
            full_op("random", {15'($urandom), 32'($urandom)}, 21'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
